// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, branch target adder and, when EXE_MUL_EN is
// defined, an iterative shift-add multiplier that stalls the pipeline.
module exe_stage #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EXE_CMD,
  input  logic [31:0] Val1,
  input  logic [31:0] Val2,
  input  logic [31:0] Reg2_in,
  input  logic [31:0] PC_in,
  input  logic        Br_taken_in,
  input  logic        WB_EN_in,
  output logic [31:0] ALU_result,
  output logic [31:0] Reg2_out,
  output logic [31:0] Br_addr,
  output logic        Br_taken,
  output logic        Stall,
  output logic        Mul_busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  logic [31:0] w_alu;

  assign Reg2_out = Reg2_in;
  assign Br_taken = Br_taken_in;
  assign Br_addr  = PC_in + {Val2[29:0], 2'b00};

  // MUL falls into the default arm: outside DONE the stage emits a zero bubble.
  always_comb begin
    w_alu = '0;
    case (EXE_CMD)
      OP_ADD:  w_alu = Val1 + Val2;
      OP_SUB:  w_alu = Val1 - Val2;
      OP_AND:  w_alu = Val1 & Val2;
      OP_OR:   w_alu = Val1 | Val2;
      OP_NOR:  w_alu = ~(Val1 | Val2);
      OP_XOR:  w_alu = Val1 ^ Val2;
      OP_SLL:  w_alu = Val1 << Val2[4:0];
      OP_SRL:  w_alu = Val1 >> Val2[4:0];
      OP_SRA:  w_alu = $unsigned($signed(Val1) >>> Val2[4:0]);
      default: w_alu = '0;
    endcase
  end

`ifdef EXE_MUL_EN
  localparam int MUL_STEPS = 32 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [5:0]  r_count;
  logic [31:0] w_partial;
  logic        w_start;

  assign w_start = (r_state == S_IDLE) && (EXE_CMD == OP_MUL) && WB_EN_in;

  // Multiplicand times the low BITS_PER_CYCLE multiplier bits, as a shift-add.
  always_comb begin
    w_partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplier[i]) w_partial = w_partial + (r_mcand << i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_BUSY;
      S_BUSY:  if (r_count == 6'(MUL_STEPS - 1)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_mcand  <= Val1;
        r_mplier <= Val2;
        r_acc    <= '0;
        r_count  <= '0;
      end else if (r_state == S_BUSY) begin
        r_acc    <= r_acc + w_partial;
        r_mcand  <= r_mcand << BITS_PER_CYCLE;
        r_mplier <= r_mplier >> BITS_PER_CYCLE;
        r_count  <= r_count + 6'd1;
      end
    end
  end

  assign Stall      = w_start || (r_state == S_BUSY);
  assign Mul_busy   = Stall;
  assign ALU_result = (r_state == S_DONE) ? r_acc : w_alu;
`else
  logic w_unused;

  assign w_unused   = clk ^ rst ^ WB_EN_in ^ (BITS_PER_CYCLE != 0);
  assign Stall      = 1'b0;
  assign Mul_busy   = 1'b0;
  assign ALU_result = w_alu;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed spec vectors, random ALU ops and,
// when EXE_MUL_EN is defined, multiplier latency/result/reset-abort checks.
module tb_exe_stage;

  localparam int TB_BPC = 1;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] br;
    logic        bt;
    logic [31:0] r2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  EXE_CMD = 4'd0;
  logic [31:0] Val1 = '0, Val2 = '0, Reg2_in = '0, PC_in = '0;
  logic        Br_taken_in = 1'b0, WB_EN_in = 1'b0;
  logic [31:0] ALU_result, Reg2_out, Br_addr;
  logic        Br_taken, Stall, Mul_busy;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  exe_stage #(.BITS_PER_CYCLE(TB_BPC)) u_dut (
    .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD), .Val1(Val1), .Val2(Val2),
    .Reg2_in(Reg2_in), .PC_in(PC_in), .Br_taken_in(Br_taken_in), .WB_EN_in(WB_EN_in),
    .ALU_result(ALU_result), .Reg2_out(Reg2_out), .Br_addr(Br_addr),
    .Br_taken(Br_taken), .Stall(Stall), .Mul_busy(Mul_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (c)
      4'b0000: r = a + b;
      4'b0010: r = a - b;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = ~(a | b);
      4'b0111: r = a ^ b;
      4'b1000: r = a << b[4:0];
      4'b1001: r = a >> b[4:0];
      4'b1010: r = $unsigned($signed(a) >>> b[4:0]);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Drive on the cycle after an edge; push the expected combinational response.
  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic bt, input logic wb,
                       input logic [31:0] exp_alu);
    exp_t e;
    @(posedge clk);
    #1;
    EXE_CMD = c; Val1 = a; Val2 = b; PC_in = pc; Br_taken_in = bt; WB_EN_in = wb;
    Reg2_in = $urandom;
    e.alu = exp_alu;
    e.br  = pc + (b << 2);
    e.bt  = bt;
    e.r2  = Reg2_in;
    exp_q.push_back(e);
  endtask

  task automatic check_comb(input string tag);
    exp_t e;
    #2;
    e = exp_q.pop_front();
    chk({tag, "_alu"}, ALU_result, e.alu);
    chk({tag, "_br"}, Br_addr, e.br);
    chk({tag, "_bt"}, {31'd0, Br_taken}, {31'd0, e.bt});
    chk({tag, "_r2"}, Reg2_out, e.r2);
    chk({tag, "_stall"}, {31'd0, Stall}, 32'd0);
  endtask

`ifdef EXE_MUL_EN
  task automatic mul_test(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] prod);
    exp_t e;
    int   n;
    drive(4'b1011, a, b, 32'h200, 1'b0, 1'b1, prod);
    #2;
    n = 0;
    while (Stall === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #3;
    end
    e = exp_q.pop_front();
    chk({tag, "_stall_cycles"}, n, 32 / TB_BPC + 1);
    chk({tag, "_result"}, ALU_result, e.alu);
    chk({tag, "_busy_done"}, {31'd0, Mul_busy}, 32'd0);
  endtask
`endif

  initial begin
    logic [3:0] ops [10];
    logic [3:0] c;
    logic [31:0] a, b;
    ops = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001,
            4'b1010, 4'b1111};

    @(posedge clk);
    #3;
    chk("reset_stall", {31'd0, Stall}, 32'd0);
    chk("reset_busy", {31'd0, Mul_busy}, 32'd0);
    rst = 1'b0;

    drive(4'b0000, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 32'h80000000);
    check_comb("add_wrap");
    drive(4'b0010, 32'h0, 32'h1, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF);
    check_comb("sub_wrap");
    drive(4'b1010, 32'h80000000, 32'h4, 32'h0, 1'b0, 1'b1, 32'hF8000000);
    check_comb("sra");
    drive(4'b1001, 32'h80000000, 32'h4, 32'h0, 1'b0, 1'b1, 32'h08000000);
    check_comb("srl");
    drive(4'b1000, 32'h1, 32'd31, 32'h0, 1'b0, 1'b1, 32'h80000000);
    check_comb("sll");
    drive(4'b0011, 32'h100, 32'hFFFFFFFF, 32'h100, 1'b1, 1'b1, 32'h0);
    check_comb("branch_unknown");
    chk("branch_addr_const", Br_addr, 32'h000000FC);

    for (int i = 0; i < 16; i++) begin
      c = ops[$urandom_range(0, 9)];
      a = $urandom;
      b = $urandom;
      drive(c, a, b, $urandom, 1'($urandom), 1'b1, ref_alu(c, a, b));
      check_comb($sformatf("rand%0d_op%0h", i, c));
    end

`ifdef EXE_MUL_EN
    drive(4'b1011, 32'd7, 32'd6, 32'h0, 1'b0, 1'b0, 32'h0);
    check_comb("mul_bubble");
    chk("mul_bubble_busy", {31'd0, Mul_busy}, 32'd0);
    mul_test("mul_7x6", 32'd7, 32'd6, 32'd42);
    mul_test("mul_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1);
    mul_test("mul_b2b", 32'h12345678, 32'h9ABCDEF1, 32'h12345678 * 32'h9ABCDEF1);

    drive(4'b1011, 32'd3, 32'd5, 32'h0, 1'b0, 1'b1, 32'h0);
    void'(exp_q.pop_front());
    #2;
    chk("abort_start_stall", {31'd0, Stall}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    WB_EN_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("abort_stall", {31'd0, Stall}, 32'd0);
    chk("abort_busy", {31'd0, Mul_busy}, 32'd0);
    chk("abort_alu", ALU_result, 32'd0);
    @(posedge clk);
    #3;
    chk("abort_bubble_stall", {31'd0, Stall}, 32'd0);
    mul_test("mul_after_abort", 32'd1000, 32'd1000, 32'd1000000);
`else
    drive(4'b1011, 32'd7, 32'd6, 32'h0, 1'b0, 1'b1, 32'h0);
    check_comb("mul_disabled");
    chk("mul_disabled_busy", {31'd0, Mul_busy}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
